// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: synchronous FIFO with programmable almost-full/almost-empty thresholds
// Ports: clk, rst (sync, active-high); wr_en/wr_data write side; rd_en/rd_data/rd_valid read side;
//   af_thresh/ae_thresh runtime thresholds; count occupancy; full/empty/almost_full/almost_empty status;
//   overflow/underflow sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_prog #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc, rd_acc;
  // Explicit wrap so non-power-of-two depths never alias.
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction
  assign count        = count_q;
  assign full         = count_q == CNT_W'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= af_thresh;
  assign almost_empty = count_q <= ae_thresh;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_acc ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? inc(rd_ptr_q) : rd_ptr_q;
    count_d  = (wr_acc && !rd_acc) ? count_q + CNT_W'(1) :
               (rd_acc && !wr_acc) ? count_q - CNT_W'(1) : count_q;
    ovf_d    = ovf_q || (wr_en && full);
    udf_d    = udf_q || (rd_en && empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= wr_data;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  always_comb begin
    rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed self-checking bench for sync_fifo_prog (DEPTH=6, WIDTH=8)
module tb_sync_fifo_prog;
  localparam int CNT_W = 3;
  logic             clk = 1'b0;
  logic             rst, wr_en, rd_en;
  logic [7:0]       wr_data, rd_data;
  logic             rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CNT_W-1:0] af_thresh, ae_thresh, count;
  int               errors = 0, checks = 0;
  sync_fifo_prog #(.DEPTH(6), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  task automatic pop(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("pop_valid", rd_valid, 1'b1);
    chk("pop_data", rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
`else
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_valid", rd_valid, 1'b1);
    chk("pop_data", rd_data, exp);
`endif
  endtask
  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    af_thresh = 3'd4; ae_thresh = 3'd1;
    step(); step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 6);
    chk("fill_af", almost_full, 1);
    push(8'h77);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 6);
    for (int i = 0; i < 6; i++) pop(8'h11 + 8'(i));
    chk("drain_empty", empty, 1);
    step();
    chk("rd_valid_one_cycle", rd_valid, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("udf_set", underflow, 1);
    chk("udf_rd_valid", rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_rd_data_hold", rd_data, 8'h16);
`endif
    for (int i = 0; i < 3; i++) push(8'h21 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'h24 + 8'(i);
`ifdef SYNC_FIFO_FWFT_EN
      chk("simul_data", rd_data, 8'h21 + 8'(i));
      step();
`else
      step();
      chk("simul_data", rd_data, 8'h21 + 8'(i));
`endif
      chk("simul_count", count, 3);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    pop(8'h2B); pop(8'h2C); pop(8'h2D);
    chk("wrap_empty", empty, 1);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("ae_c%0d", c), almost_empty, c <= 1);
      chk($sformatf("af_c%0d", c), almost_full, c >= 4);
      if (c < 5) push(8'h30 + 8'(c));
    end
    chk("ramp_count", count, 5);
    af_thresh = 3'd6;
    #1;
    chk("af_thresh_live", almost_full, 0);
    af_thresh = 3'd4;
    pop(8'h30);
    chk("pre_rst_count", count, 4);
    chk("pre_rst_ovf", overflow, 1);
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    step();
    rst = 1'b0;
    wr_en = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_udf", underflow, 0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_udf", underflow, 1);
    pop(8'h5A);
    chk("post_rst_empty", empty, 1);
    push(8'hA5);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_valid", rd_valid, 1);
    chk("fwft_data", rd_data, 8'hA5);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_pop_empty", empty, 1);
    chk("fwft_pop_valid", rd_valid, 0);
`else
    chk("nofwft_no_pop_valid", rd_valid, 0);
    chk("nofwft_data_held", rd_data, 8'h5A);
    pop(8'hA5);
    chk("nofwft_pop_empty", empty, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
